id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, directly downstream of the main control decoder and register file.
- Latches the decoder's control bundle, operand data, immediate, function bits and register addresses for EX.
- Contains the load-use hazard detector, which stalls PC and IF/ID and injects a bubble into EX.
- Keeps stall and issue performance counters.

Parameters:
- DATA_W, 32, width of register data, immediate and PC.
- RADDR_W, 5, register address width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  core run enable; while low, the stage captures bubbles only.
- flush_i  in  1  kill the instruction currently in ID.
- branch_i  in  1  control bundle input from the decoder: Branch.
- memtoreg_i  in  1  control bundle input from the decoder: MemtoReg.
- aluop_i  in  2  control bundle input from the decoder: ALUOp.
- memwrite_i  in  1  control bundle input from the decoder: MemWrite.
- alusrc_i  in  1  control bundle input from the decoder: ALUSrc.
- regwrite_i  in  1  control bundle input from the decoder: RegWrite.
- memread_i  in  1  decoded load indication.
- rs1_data_i  in  DATA_W  register file read port 1.
- rs2_data_i  in  DATA_W  register file read port 2.
- imm_i  in  DATA_W  sign-extended immediate.
- pc_i  in  DATA_W  PC of the ID instruction.
- funct_i  in  10  {funct7, funct3}.
- rs1_addr_i  in  RADDR_W  source register 1 address.
- rs2_addr_i  in  RADDR_W  source register 2 address.
- rd_addr_i  in  RADDR_W  destination register address.
- stall_o  out  1  combinational; holds PC and IF/ID when high.
- valid_o  out  1  EX holds a real instruction.
- memtoreg_o, aluop_o[1:0], memwrite_o, alusrc_o, regwrite_o, memread_o  out  registered control bundle.
- rs1_data_o, rs2_data_o, imm_o, pc_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o  out  registered data fields, same widths as the inputs.
- stall_cnt_o  out  CNT_W  count of cycles in which stall_o was high.
- issue_cnt_o  out  CNT_W  count of real instructions issued to EX.

Behaviour:
- Reset (rst_i low, asynchronous):
  - All registered outputs go to 0, including valid_o, both counters and all data fields.
  - Reset takes effect mid-operation without waiting for a clock edge.
  - The first capture happens on the first rising edge after rst_i goes high.
- Load-use detection (combinational):
  - load_use = valid_o & memread_o & (rd_addr_o != 0) & ((rd_addr_o == rs1_addr_i) | (rd_addr_o == rs2_addr_i)).
  - stall_o = load_use & ~flush_i & start_i.
- Capture per rising edge, highest priority first:
  - start_i low: bubble.
  - flush_i high: bubble. stall_o is suppressed, because the killed instruction needs no stall.
  - stall_o high: bubble. The ID instruction stays in ID and is re-presented next cycle.
  - Otherwise: normal capture of every input; valid_o = 1.
- Bubble definition:
  - valid_o = 0; memtoreg, aluop, memwrite, alusrc, regwrite and memread all 0.
  - Data fields still capture their inputs; they are don't-care to EX.
- Latency: 1 cycle from ID inputs to EX outputs. No combinational path from inputs to registered outputs.
- branch_i has no EX output. It is used in ID only; the stage ignores it except that the hazard check still applies to branch operands.
- Counters:
  - stall_cnt_o increments on each edge where stall_o is high.
  - issue_cnt_o increments on each normal capture.
  - Both saturate at 2^CNT_W - 1 and never wrap.
- Back-to-back loads:
  - The stall lasts exactly 1 cycle. After the bubble, valid_o = 0, so load_use drops and the dependent instruction issues.
  - The following stage forwards from MEM.
- rd_addr_o = 0 (x0 destination) never causes a stall.

Test Plan:
- Reset behaviour -> hold rst_i low mid-stream with regwrite_o = 1, valid_o = 1 -> all outputs read 0 immediately, before any clock edge; first capture after release.
- Pass-through latency -> start_i = 1; present add x3,x1,x2 (regwrite_i = 1, alusrc_i = 0, aluop_i = 2'b10, rs1_data_i = 5, rs2_data_i = 7) -> exactly one edge later valid_o = 1, regwrite_o = 1, rs1_data_o = 5, rs2_data_o = 7, aluop_o = 2'b10; issue_cnt_o = 1.
- Load-use stall -> lw x5 in EX (memread_o = 1, rd_addr_o = 5); ID has rs2_addr_i = 5 -> stall_o = 1 for one cycle; next edge produces a bubble (valid_o = 0, all control 0); the following edge issues the dependent instruction; stall_cnt_o = 1.
- x0 and no-match cases -> lw x0 in EX with rs1_addr_i = 0 -> stall_o = 0; lw x6 in EX with rs1_addr_i = 7, rs2_addr_i = 8 -> stall_o = 0.
- Flush with simultaneous hazard -> load-use condition true and flush_i = 1 -> stall_o = 0; next edge gives a bubble; stall_cnt_o unchanged.
- Counter saturation -> CNT_W = 4; issue 20 consecutive instructions -> issue_cnt_o reaches 15 and holds at 15 with no wrap to 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and saturating
// stall/issue performance counters.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               flush_i,
    input  logic               branch_i,
    input  logic               memtoreg_i,
    input  logic [1:0]         aluop_i,
    input  logic               memwrite_i,
    input  logic               alusrc_i,
    input  logic               regwrite_i,
    input  logic               memread_i,
    input  logic [DATA_W-1:0]  rs1_data_i,
    input  logic [DATA_W-1:0]  rs2_data_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [DATA_W-1:0]  pc_i,
    input  logic [9:0]         funct_i,
    input  logic [RADDR_W-1:0] rs1_addr_i,
    input  logic [RADDR_W-1:0] rs2_addr_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    output logic               stall_o,
    output logic               valid_o,
    output logic               memtoreg_o,
    output logic [1:0]         aluop_o,
    output logic               memwrite_o,
    output logic               alusrc_o,
    output logic               regwrite_o,
    output logic               memread_o,
    output logic [DATA_W-1:0]  rs1_data_o,
    output logic [DATA_W-1:0]  rs2_data_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [DATA_W-1:0]  pc_o,
    output logic [9:0]         funct_o,
    output logic [RADDR_W-1:0] rs1_addr_o,
    output logic [RADDR_W-1:0] rs2_addr_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   issue_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               valid_q, valid_d;
    logic               memtoreg_q, memtoreg_d;
    logic [1:0]         aluop_q, aluop_d;
    logic               memwrite_q, memwrite_d;
    logic               alusrc_q, alusrc_d;
    logic               regwrite_q, regwrite_d;
    logic               memread_q, memread_d;
    logic [DATA_W-1:0]  rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0]  rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [9:0]         funct_q, funct_d;
    logic [RADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [RADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;

    logic load_use;
    logic issue;
    logic branch_unused;

    // Branch resolves in ID; its operands are still covered by the hazard check.
    assign branch_unused = branch_i;

    always_comb begin
        load_use = valid_q & memread_q & (rd_addr_q != '0) &
                   ((rd_addr_q == rs1_addr_i) | (rd_addr_q == rs2_addr_i));
        stall_o  = load_use & ~flush_i & start_i;
        issue    = start_i & ~flush_i & ~stall_o;
    end

    always_comb begin
        valid_d     = issue;
        memtoreg_d  = issue & memtoreg_i;
        aluop_d     = issue ? aluop_i : 2'b00;
        memwrite_d  = issue & memwrite_i;
        alusrc_d    = issue & alusrc_i;
        regwrite_d  = issue & regwrite_i;
        memread_d   = issue & memread_i;
        // Data fields follow the inputs even on bubbles; EX ignores them then.
        rs1_data_d  = rs1_data_i;
        rs2_data_d  = rs2_data_i;
        imm_d       = imm_i;
        pc_d        = pc_i;
        funct_d     = funct_i;
        rs1_addr_d  = rs1_addr_i;
        rs2_addr_d  = rs2_addr_i;
        rd_addr_d   = rd_addr_i;
        stall_cnt_d = stall_cnt_q;
        issue_cnt_d = issue_cnt_q;
        if (stall_o && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (issue && issue_cnt_q != CNT_MAX) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q     <= 1'b0;
            memtoreg_q  <= 1'b0;
            aluop_q     <= 2'b00;
            memwrite_q  <= 1'b0;
            alusrc_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            funct_q     <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            memtoreg_q  <= memtoreg_d;
            aluop_q     <= aluop_d;
            memwrite_q  <= memwrite_d;
            alusrc_q    <= alusrc_d;
            regwrite_q  <= regwrite_d;
            memread_q   <= memread_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            funct_q     <= funct_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign memtoreg_o  = memtoreg_q;
    assign aluop_o     = aluop_q;
    assign memwrite_o  = memwrite_q;
    assign alusrc_o    = alusrc_q;
    assign regwrite_o  = regwrite_q;
    assign memread_o   = memread_q;
    assign rs1_data_o  = rs1_data_q;
    assign rs2_data_o  = rs2_data_q;
    assign imm_o       = imm_q;
    assign pc_o        = pc_q;
    assign funct_o     = funct_q;
    assign rs1_addr_o  = rs1_addr_q;
    assign rs2_addr_o  = rs2_addr_q;
    assign rd_addr_o   = rd_addr_q;
    assign stall_cnt_o = stall_cnt_q;
    assign issue_cnt_o = issue_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_id_ex_stage;

    localparam int DW      = 32;
    localparam int AW      = 5;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk_i, rst_i, start_i, flush_i, branch_i;
    logic          memtoreg_i, memwrite_i, alusrc_i, regwrite_i, memread_i;
    logic [1:0]    aluop_i;
    logic [DW-1:0] rs1_data_i, rs2_data_i, imm_i, pc_i;
    logic [9:0]    funct_i;
    logic [AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic          stall_o, valid_o, memtoreg_o, memwrite_o, alusrc_o, regwrite_o, memread_o;
    logic [1:0]    aluop_o;
    logic [DW-1:0] rs1_data_o, rs2_data_o, imm_o, pc_o;
    logic [9:0]    funct_o;
    logic [AW-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [CW-1:0] stall_cnt_o, issue_cnt_o;

    id_ex_stage #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
        .branch_i(branch_i), .memtoreg_i(memtoreg_i), .aluop_i(aluop_i),
        .memwrite_i(memwrite_i), .alusrc_i(alusrc_i), .regwrite_i(regwrite_i),
        .memread_i(memread_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .imm_i(imm_i), .pc_i(pc_i), .funct_i(funct_i), .rs1_addr_i(rs1_addr_i),
        .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .stall_o(stall_o),
        .valid_o(valid_o), .memtoreg_o(memtoreg_o), .aluop_o(aluop_o),
        .memwrite_o(memwrite_o), .alusrc_o(alusrc_o), .regwrite_o(regwrite_o),
        .memread_o(memread_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .pc_o(pc_o), .funct_o(funct_o), .rs1_addr_o(rs1_addr_o),
        .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .stall_cnt_o(stall_cnt_o), .issue_cnt_o(issue_cnt_o)
    );

    typedef struct {
        logic          start, flush, branch, memtoreg, memwrite, alusrc, regwrite, memread;
        logic [1:0]    aluop;
        logic [DW-1:0] rs1d, rs2d, imm, pc;
        logic [9:0]    funct;
        logic [AW-1:0] rs1a, rs2a, rd;
    } stim_t;

    typedef struct {
        logic          valid, memtoreg, memwrite, alusrc, regwrite, memread;
        logic [1:0]    aluop;
        logic [DW-1:0] rs1d, rs2d, imm, pc;
        logic [9:0]    funct;
        logic [AW-1:0] rs1a, rs2a, rd;
        int            sc, ic;
    } ex_t;

    typedef struct {
        logic stall;
        ex_t  ex;
    } exp_t;

    exp_t sb_q[$];
    ex_t  m;
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic ex_t zero_ex();
        ex_t z;
        z.valid = 0; z.memtoreg = 0; z.memwrite = 0; z.alusrc = 0; z.regwrite = 0;
        z.memread = 0; z.aluop = 0; z.rs1d = 0; z.rs2d = 0; z.imm = 0; z.pc = 0;
        z.funct = 0; z.rs1a = 0; z.rs2a = 0; z.rd = 0; z.sc = 0; z.ic = 0;
        return z;
    endfunction

    // A plain ALU instruction with random data and no register dependences set.
    function automatic stim_t base_stim();
        stim_t s;
        s.start = 1; s.flush = 0; s.branch = 0; s.memtoreg = 0; s.memwrite = 0;
        s.alusrc = 0; s.regwrite = 1; s.memread = 0; s.aluop = 2'b10;
        s.rs1d = $urandom; s.rs2d = $urandom; s.imm = $urandom; s.pc = $urandom;
        s.funct = 10'($urandom); s.rs1a = 5'd10; s.rs2a = 5'd11; s.rd = 5'd12;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s          = base_stim();
        s.start    = ($urandom_range(0, 7) != 0);
        s.flush    = ($urandom_range(0, 7) == 0);
        s.branch   = 1'($urandom);
        s.memtoreg = 1'($urandom);
        s.memwrite = 1'($urandom);
        s.alusrc   = 1'($urandom);
        s.regwrite = 1'($urandom);
        s.memread  = 1'($urandom);
        s.aluop    = 2'($urandom);
        s.rs1a     = 5'($urandom_range(0, 3));
        s.rs2a     = 5'($urandom_range(0, 3));
        s.rd       = 5'($urandom_range(0, 3));
        return s;
    endfunction

    // Drive one ID instruction at a falling edge and record what EX must show after the next rising edge.
    task automatic apply_stimulus(input stim_t s);
        exp_t e;
        logic hazard, issue;
        start_i = s.start; flush_i = s.flush; branch_i = s.branch;
        memtoreg_i = s.memtoreg; aluop_i = s.aluop; memwrite_i = s.memwrite;
        alusrc_i = s.alusrc; regwrite_i = s.regwrite; memread_i = s.memread;
        rs1_data_i = s.rs1d; rs2_data_i = s.rs2d; imm_i = s.imm; pc_i = s.pc;
        funct_i = s.funct; rs1_addr_i = s.rs1a; rs2_addr_i = s.rs2a; rd_addr_i = s.rd;
        hazard  = m.valid && m.memread && (m.rd != 0) && (m.rd == s.rs1a || m.rd == s.rs2a);
        e.stall = hazard && !s.flush && s.start;
        issue   = s.start && !s.flush && !e.stall;
        m.valid    = issue;
        m.memtoreg = issue ? s.memtoreg : 1'b0;
        m.aluop    = issue ? s.aluop : 2'b00;
        m.memwrite = issue ? s.memwrite : 1'b0;
        m.alusrc   = issue ? s.alusrc : 1'b0;
        m.regwrite = issue ? s.regwrite : 1'b0;
        m.memread  = issue ? s.memread : 1'b0;
        m.rs1d = s.rs1d; m.rs2d = s.rs2d; m.imm = s.imm; m.pc = s.pc;
        m.funct = s.funct; m.rs1a = s.rs1a; m.rs2a = s.rs2a; m.rd = s.rd;
        if (e.stall && m.sc < CNT_MAX) m.sc++;
        if (issue && m.ic < CNT_MAX) m.ic++;
        e.ex = m;
        sb_q.push_back(e);
        @(negedge clk_i);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic do_reset();
        #2 rst_i = 1'b0;
        #1;
        check_output("rst_valid", valid_o, 0);
        check_output("rst_ctrl", {memtoreg_o, aluop_o, memwrite_o, alusrc_o, regwrite_o, memread_o}, 0);
        check_output("rst_stall_cnt", stall_cnt_o, 0);
        check_output("rst_issue_cnt", issue_cnt_o, 0);
        check_output("rst_rs1_data", rs1_data_o, 0);
        check_output("rst_pc", pc_o, 0);
        check_output("rst_addrs", {rs1_addr_o, rs2_addr_o, rd_addr_o, funct_o}, 0);
        check_output("rst_stall", stall_o, 0);
        m = zero_ex();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Monitor: stall is checked mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #3;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_output("stall_o", stall_o, e.stall);
                @(posedge clk_i);
                #1;
                check_output("valid_o", valid_o, e.ex.valid);
                check_output("ctrl", {memtoreg_o, aluop_o, memwrite_o, alusrc_o, regwrite_o, memread_o},
                             {e.ex.memtoreg, e.ex.aluop, e.ex.memwrite, e.ex.alusrc, e.ex.regwrite, e.ex.memread});
                check_output("rs1_data_o", rs1_data_o, e.ex.rs1d);
                check_output("rs2_data_o", rs2_data_o, e.ex.rs2d);
                check_output("imm_o", imm_o, e.ex.imm);
                check_output("pc_o", pc_o, e.ex.pc);
                check_output("funct_addrs", {funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o},
                             {e.ex.funct, e.ex.rs1a, e.ex.rs2a, e.ex.rd});
                check_output("stall_cnt_o", stall_cnt_o, e.ex.sc[CW-1:0]);
                check_output("issue_cnt_o", issue_cnt_o, e.ex.ic[CW-1:0]);
            end
        end
    end

    initial begin
        stim_t s, dep;
        m = zero_ex();
        rst_i = 1'b0;
        s = base_stim();
        s.start = 0;
        apply_stimulus(s);
        sb_q.delete();
        do_reset();

        s = base_stim();
        s.rs1a = 1; s.rs2a = 2; s.rd = 3; s.rs1d = 5; s.rs2d = 7;
        apply_stimulus(s);
        check_output("add_valid", valid_o, 1);
        check_output("add_rs1", rs1_data_o, 5);
        check_output("add_rs2", rs2_data_o, 7);
        check_output("add_aluop", aluop_o, 2'b10);
        check_output("add_issue_cnt", issue_cnt_o, 1);

        s = base_stim();
        s.memread = 1; s.memtoreg = 1; s.alusrc = 1; s.aluop = 2'b00; s.rs1a = 1; s.rd = 5;
        apply_stimulus(s);
        dep = base_stim();
        dep.rs1a = 6; dep.rs2a = 5; dep.rd = 7;
        apply_stimulus(dep);
        check_output("bubble_valid", valid_o, 0);
        check_output("bubble_regwrite", regwrite_o, 0);
        check_output("bubble_stall_cnt", stall_cnt_o, 1);
        apply_stimulus(dep);
        check_output("dep_issued", valid_o, 1);

        s = base_stim();
        s.memread = 1; s.rd = 0;
        apply_stimulus(s);
        s = base_stim();
        s.rs1a = 0;
        apply_stimulus(s);
        s = base_stim();
        s.memread = 1; s.rd = 6;
        apply_stimulus(s);
        s = base_stim();
        s.rs1a = 7; s.rs2a = 8;
        apply_stimulus(s);

        s = base_stim();
        s.memread = 1; s.rd = 5;
        apply_stimulus(s);
        s = base_stim();
        s.rs1a = 5; s.flush = 1;
        apply_stimulus(s);
        check_output("flush_valid", valid_o, 0);
        check_output("flush_stall_cnt", stall_cnt_o, 1);

        for (int i = 0; i < 20; i++) apply_stimulus(base_stim());
        check_output("issue_saturated", issue_cnt_o, CNT_MAX);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 50) do_reset();
            apply_stimulus(rand_stim());
        end

        repeat (2) @(negedge clk_i);
        check_output("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
